step_phase_driver: RTL

//  Receiving end of the step/dir interface: consumes the step pulse train and direction bit

---
 rtl/stepper_pkg.sv | 24 ++
 rtl/step_pulse_filter.sv | 74 +++++++
 rtl/step_phase_driver.sv | 92 +++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared definitions for the step/dir interface: coil phase table, pulse filter states and
// default position width.
package stepper_pkg;

  localparam int unsigned PosWDefault = 32;

  typedef enum logic [1:0] {
    StIdle,
    StHighCnt,
    StWaitLow
  } filt_state_e;

  // Entry 0 is the rightmost nibble; odd entries are the two-coils-on phases.
  localparam logic [7:0][3:0] CoilTable = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic logic [3:0] coil_lookup(logic [2:0] idx, logic half);
    logic [2:0] sel;
    sel = half ? idx : {idx[2:1], 1'b1};
    return CoilTable[sel];
  endfunction

endpackage

// File: rtl/step_pulse_filter.sv
// Synchronizes step/dir and accepts a step only after MIN_HIGH consecutive high cycles;
// shorter highs raise a one-cycle glitch pulse.
module step_pulse_filter
  import stepper_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HIGH    = 4
) (
  input  logic clock_in,
  input  logic reset,
  input  logic step_in,
  input  logic dir_in,
  output logic strobe,
  output logic dir_out,
  output logic glitch
);

  localparam int unsigned CntW = $clog2(MIN_HIGH + 1);

  logic [SYNC_STAGES-1:0] step_sync_q, dir_sync_q, fill_q;
  logic [CntW-1:0]        cnt_q;
  filt_state_e            state_q;
  logic                   dir_q, glitch_q;
  logic                   step_s, dir_s, filled;

  assign step_s  = step_sync_q[SYNC_STAGES-1];
  assign dir_s   = dir_sync_q[SYNC_STAGES-1];
  // Until the chain has refilled since reset, a low output says nothing about step_in.
  assign filled  = fill_q[SYNC_STAGES-1];
  assign strobe  = (state_q == StHighCnt) && (cnt_q == CntW'(MIN_HIGH));
  assign dir_out = dir_q;
  assign glitch  = glitch_q;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      step_sync_q <= '0;
      dir_sync_q  <= '0;
      fill_q      <= '0;
      state_q     <= StWaitLow;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      glitch_q    <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step_in};
      dir_sync_q  <= {dir_sync_q[SYNC_STAGES-2:0], dir_in};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      glitch_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (step_s) begin
            state_q <= StHighCnt;
            cnt_q   <= CntW'(1);
            dir_q   <= dir_s;
          end
        end
        StHighCnt: begin
          if (cnt_q == CntW'(MIN_HIGH)) begin
            state_q <= StWaitLow;
          end else if (!step_s) begin
            state_q  <= StIdle;
            glitch_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitLow: begin
          if (!step_s && filled) state_q <= StIdle;
        end
        default: state_q <= StWaitLow;
      endcase
    end
  end

endmodule

// File: rtl/step_phase_driver.sv
// Stepper coil driver: applies filtered steps to a half/full-step phase index and a signed
// position, and flags arrival at a host-loaded target.
module step_phase_driver
  import stepper_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HIGH    = 4,
  parameter int unsigned POS_W       = PosWDefault
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             enable,
  input  logic             half_step,
  input  logic             target_valid,
  input  logic [POS_W-1:0] target,
  output logic             target_ready,
  output logic [3:0]       coil_out,
  output logic [POS_W-1:0] position,
  output logic             at_target,
  output logic             step_ack,
  output logic             glitch_err
);

  logic             strobe, step_dir, glitch, apply, load;
  logic [2:0]       idx_q, idx_d, idx_inc;
  logic [POS_W-1:0] pos_q, pos_d, tgt_q;
  logic [3:0]       coil_q;
  logic             ack_q, at_q, err_q, loaded_q;

  step_pulse_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_HIGH   (MIN_HIGH)
  ) u_filter (
    .clock_in(clock_in),
    .reset   (reset),
    .step_in (step_in),
    .dir_in  (dir_in),
    .strobe  (strobe),
    .dir_out (step_dir),
    .glitch  (glitch)
  );

  assign apply        = strobe & enable;
  // Loads are held off while a step lands so at_target compares against a stable position.
  assign target_ready = ~apply;
  assign load         = target_valid & target_ready;

  always_comb begin
    idx_d   = idx_q;
    pos_d   = pos_q;
    idx_inc = half_step ? 3'd1 : 3'd2;
    if (apply) begin
      idx_d = step_dir ? idx_q + idx_inc : idx_q - idx_inc;
      pos_d = step_dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      pos_q    <= '0;
      coil_q   <= '0;
      ack_q    <= 1'b0;
      at_q     <= 1'b0;
      err_q    <= 1'b0;
      tgt_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pos_q  <= pos_d;
      coil_q <= enable ? coil_lookup(idx_d, half_step) : 4'b0000;
      ack_q  <= apply;
      at_q   <= loaded_q && (pos_q == tgt_q);
      if (load) begin
        tgt_q    <= target;
        loaded_q <= 1'b1;
        err_q    <= 1'b0;
      end else if (glitch) begin
        err_q <= 1'b1;
      end
    end
  end

  assign coil_out   = coil_q;
  assign position   = pos_q;
  assign at_target  = at_q;
  assign step_ack   = ack_q;
  assign glitch_err = err_q;

endmodule
